// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared types and sizes for the register file and its scoreboard
package register_file_pkg;

  localparam int REG_NUM             = 32;
  localparam int DEFAULT_PENDING_MAX = 3;

  typedef logic [31:0] BasicData;
  typedef logic [4:0]  RegAddr;

  // Counter type for the default depth; the scoreboard re-derives its width from its own parameter
  typedef logic [$clog2(DEFAULT_PENDING_MAX+1)-1:0] PendingCount;

endpackage

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - per-register pending-write counters with sticky error flag
module reg_scoreboard
  import register_file_pkg::*;
#(
  parameter int PENDING_MAX = DEFAULT_PENDING_MAX
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   issueValid,
  input  RegAddr issueRdAddr,
  input  logic   wEnable,
  input  RegAddr rdAddr,
  input  logic   flush,
  input  RegAddr rs1Addr,
  input  RegAddr rs2Addr,
  input  logic   rs1Retire,
  input  logic   rs2Retire,
  output logic   rs1Busy,
  output logic   rs2Busy,
  output logic   sbError
);

  localparam int CW = $clog2(PENDING_MAX + 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(PENDING_MAX);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0] count     [REG_NUM];
  logic [CW-1:0] countNext [REG_NUM];
  logic          errNext;
  logic          issueHit;
  logic          writeHit;
  logic [CW-1:0] rs1Count;
  logic [CW-1:0] rs2Count;

  // Next counter values: flush wins, a same-register issue+write cancels, otherwise saturate at both ends
  always_comb begin
    errNext  = sbError;
    issueHit = 1'b0;
    writeHit = 1'b0;
    for (int r = 0; r < REG_NUM; r++) begin
      countNext[r] = count[r];
    end
    countNext[0] = '0;
    if (flush) begin
      for (int r = 0; r < REG_NUM; r++) begin
        countNext[r] = '0;
      end
      errNext = 1'b0;
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        issueHit = issueValid && (issueRdAddr == RegAddr'(r));
        writeHit = wEnable && (rdAddr == RegAddr'(r));
        if (issueHit && !writeHit) begin
          if (count[r] == MAX_COUNT) begin
            errNext = 1'b1;
          end else begin
            countNext[r] = count[r] + ONE;
          end
        end else if (writeHit && !issueHit) begin
          if (count[r] == '0) begin
            errNext = 1'b1;
          end else begin
            countNext[r] = count[r] - ONE;
          end
        end
      end
    end
  end

  // Counter array and sticky error register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        count[r] <= '0;
      end
      sbError <= 1'b0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        count[r] <= countNext[r];
      end
      sbError <= errNext;
    end
  end

  // Busy lookups; a retiring write in the same cycle no longer counts as outstanding
  always_comb begin
    rs1Count = count[rs1Addr];
    rs2Count = count[rs2Addr];
    rs1Busy  = rs1Retire ? (rs1Count > ONE) : (rs1Count != '0);
    rs2Busy  = rs2Retire ? (rs2Count > ONE) : (rs2Count != '0);
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - x0-hardwired register file with pending-write scoreboard; REGFILE_BYPASS_EN adds write-back forwarding
module register_file
  import register_file_pkg::*;
#(
  parameter int PENDING_MAX = DEFAULT_PENDING_MAX
) (
  input  logic     clk,
  input  logic     rst,
  input  RegAddr   rs1Addr,
  input  RegAddr   rs2Addr,
  output BasicData rs1Data,
  output BasicData rs2Data,
  output logic     rs1Busy,
  output logic     rs2Busy,
  input  logic     issueValid,
  input  RegAddr   issueRdAddr,
  input  logic     wEnable,
  input  RegAddr   rdAddr,
  input  BasicData wData,
  input  logic     flush,
  output logic     sbError
);

  BasicData regs [REG_NUM];
  logic     rs1Fwd;
  logic     rs2Fwd;

  // Data array; x0 is only ever written by reset so it stays zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs[r] <= '0;
      end
    end else if (wEnable && (rdAddr != '0)) begin
      regs[rdAddr] <= wData;
    end
  end

  // Read muxes, optionally forwarding the write-back value of this cycle
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rs1Fwd = wEnable && (rdAddr == rs1Addr) && (rdAddr != '0);
    rs2Fwd = wEnable && (rdAddr == rs2Addr) && (rdAddr != '0);
`else
    rs1Fwd = 1'b0;
    rs2Fwd = 1'b0;
`endif
    rs1Data = rs1Fwd ? wData : regs[rs1Addr];
    rs2Data = rs2Fwd ? wData : regs[rs2Addr];
  end

  reg_scoreboard #(
    .PENDING_MAX(PENDING_MAX)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issueValid (issueValid),
    .issueRdAddr(issueRdAddr),
    .wEnable    (wEnable),
    .rdAddr     (rdAddr),
    .flush      (flush),
    .rs1Addr    (rs1Addr),
    .rs2Addr    (rs2Addr),
    .rs1Retire  (rs1Fwd),
    .rs2Retire  (rs2Fwd),
    .rs1Busy    (rs1Busy),
    .rs2Busy    (rs2Busy),
    .sbError    (sbError)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized and directed self-checking bench for register_file
module tb_register_file;
  import register_file_pkg::*;

  localparam int PMAX = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic     clk = 1'b0;
  logic     rst = 1'b0;
  RegAddr   rs1Addr = '0, rs2Addr = '0, issueRdAddr = '0, rdAddr = '0;
  BasicData rs1Data, rs2Data, wData = '0;
  logic     rs1Busy, rs2Busy, sbError;
  logic     issueValid = 1'b0, wEnable = 1'b0, flush = 1'b0;

  int checks = 0;
  int failures = 0;
  bit cmpEn = 1'b0;

  // Reference model: architectural values and outstanding-write counts as plain integers
  logic [31:0] mReg [32];
  int          mCnt [32];
  bit          mErr;

  register_file #(.PENDING_MAX(PMAX)) dut (
    .clk(clk), .rst(rst),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
    .issueValid(issueValid), .issueRdAddr(issueRdAddr),
    .wEnable(wEnable), .rdAddr(rdAddr), .wData(wData),
    .flush(flush), .sbError(sbError)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mReg[i] = '0;
      mCnt[i] = 0;
    end
    mErr = 1'b0;
  endtask

  function automatic logic [31:0] expData(input RegAddr a);
    if (BYP && wEnable && rdAddr == a && a != 0) return wData;
    return mReg[a];
  endfunction

  function automatic logic expBusy(input RegAddr a);
    if (BYP && wEnable && rdAddr == a && a != 0) return mCnt[a] > 1;
    return mCnt[a] != 0;
  endfunction

  // Every cycle: outputs must follow the model given the inputs presented this cycle
  always @(negedge clk) begin
    if (rst && cmpEn) begin
      chk("rs1Data", rs1Data, expData(rs1Addr));
      chk("rs2Data", rs2Data, expData(rs2Addr));
      chk("rs1Busy", 32'(rs1Busy), 32'(expBusy(rs1Addr)));
      chk("rs2Busy", 32'(rs2Busy), 32'(expBusy(rs2Addr)));
      chk("sbError", 32'(sbError), 32'(mErr));
    end
  end

  // One clock edge: advance the model from the inputs held across it
  task automatic step();
    bit iss, wr;
    @(posedge clk);
    iss = issueValid && issueRdAddr != 0;
    wr  = wEnable && rdAddr != 0;
    if (wr) mReg[rdAddr] = wData;
    if (flush) begin
      for (int i = 0; i < 32; i++) mCnt[i] = 0;
      mErr = 1'b0;
    end else if (!(iss && wr && issueRdAddr == rdAddr)) begin
      if (iss) begin
        if (mCnt[issueRdAddr] == PMAX) mErr = 1'b1;
        else mCnt[issueRdAddr]++;
      end
      if (wr) begin
        if (mCnt[rdAddr] == 0) mErr = 1'b1;
        else mCnt[rdAddr]--;
      end
    end
    #1;
  endtask

  task automatic idle();
    issueValid = 1'b0;
    wEnable    = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic atNeg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    modelReset();
    #3;
    rs1Addr = 5'd1; rs2Addr = 5'd31;
    #1;
    chk("reset_rs1Data", rs1Data, 32'h0);
    chk("reset_rs2Busy", 32'(rs2Busy), 32'h0);
    chk("reset_sbError", 32'(sbError), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b1;
    cmpEn = 1'b1;
    atNeg();
    chk("x1_data", rs1Data, 32'h0);
    chk("x31_busy", 32'(rs2Busy), 32'h0);

    // x0 write ignored
    rs1Addr = 5'd0; wEnable = 1'b1; rdAddr = 5'd0; wData = 32'hDEADBEEF;
    step(); idle();
    atNeg();
    chk("x0_zero", rs1Data, 32'h0);

    // issue x5, write two edges later
    rs1Addr = 5'd5; issueValid = 1'b1; issueRdAddr = 5'd5;
    step(); idle();
    atNeg();
    chk("x5_busy_after_issue", 32'(rs1Busy), 32'h1);
    step();
    wEnable = 1'b1; rdAddr = 5'd5; wData = 32'h12345678;
    atNeg();
    chk("x5_data_wcycle", rs1Data, BYP ? 32'h12345678 : 32'h0);
    chk("x5_busy_wcycle", 32'(rs1Busy), BYP ? 32'h0 : 32'h1);
    step(); idle();
    atNeg();
    chk("x5_data_after", rs1Data, 32'h12345678);
    chk("x5_busy_after", 32'(rs1Busy), 32'h0);

    // three outstanding writes to x7
    rs1Addr = 5'd7; issueValid = 1'b1; issueRdAddr = 5'd7;
    repeat (3) step();
    idle(); wEnable = 1'b1; rdAddr = 5'd7; wData = 32'h7;
    step(); idle();
    atNeg();
    chk("x7_busy_after_1w", 32'(rs1Busy), 32'h1);
    wEnable = 1'b1;
    step();
    atNeg();
    chk("x7_busy_after_2w", 32'(rs1Busy), BYP ? 32'h0 : 32'h1);
    step(); idle();
    atNeg();
    chk("x7_busy_after_3w", 32'(rs1Busy), 32'h0);
    chk("x7_no_err", 32'(sbError), 32'h0);

    // same-cycle issue and write to x9
    rs1Addr = 5'd9; issueValid = 1'b1; issueRdAddr = 5'd9;
    step();
    wEnable = 1'b1; rdAddr = 5'd9; wData = 32'h99;
    step(); idle();
    atNeg();
    chk("x9_busy_cancel", 32'(rs1Busy), 32'h1);
    wEnable = 1'b1; rdAddr = 5'd9;
    step(); idle();
    atNeg();
    chk("x9_busy_done", 32'(rs1Busy), 32'h0);

    // overflow x3
    rs1Addr = 5'd3; rs2Addr = 5'd7; issueValid = 1'b1; issueRdAddr = 5'd3;
    repeat (4) step();
    idle();
    atNeg();
    chk("x3_overflow_err", 32'(sbError), 32'h1);
    chk("x3_busy_sat", 32'(rs1Busy), 32'h1);
    step();
    atNeg();
    chk("x3_err_held", 32'(sbError), 32'h1);
    flush = 1'b1;
    step(); idle();
    atNeg();
    chk("flush_busy", 32'(rs1Busy), 32'h0);
    chk("flush_err", 32'(sbError), 32'h0);

    // flush together with issue and write to x4
    rs1Addr = 5'd4; flush = 1'b1; issueValid = 1'b1; issueRdAddr = 5'd4;
    wEnable = 1'b1; rdAddr = 5'd4; wData = 32'hA5A5A5A5;
    step(); idle();
    atNeg();
    chk("x4_busy_flush", 32'(rs1Busy), 32'h0);
    chk("x4_data_flush", rs1Data, 32'hA5A5A5A5);

    // randomized traffic, addresses concentrated to provoke hazards and saturation
    for (int c = 0; c < 3000; c++) begin
      rs1Addr     = ($urandom_range(0, 9) == 0) ? RegAddr'($urandom) : RegAddr'($urandom_range(0, 6));
      rs2Addr     = RegAddr'($urandom_range(0, 6));
      issueValid  = $urandom_range(0, 1) == 1;
      issueRdAddr = RegAddr'($urandom_range(0, 6));
      wEnable     = $urandom_range(0, 2) != 0;
      rdAddr      = RegAddr'($urandom_range(0, 6));
      wData       = $urandom;
      flush       = $urandom_range(0, 49) == 0;
      step();
    end
    idle();

    // asynchronous reset in the middle of activity
    rs1Addr = 5'd6; rs2Addr = 5'd2;
    issueValid = 1'b1; issueRdAddr = 5'd6; wEnable = 1'b1; rdAddr = 5'd2; wData = 32'hCAFEF00D;
    step(); idle();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rs1Busy", 32'(rs1Busy), 32'h0);
    chk("async_rs2Data", rs2Data, 32'h0);
    chk("async_sbError", 32'(sbError), 32'h0);
    modelReset();
    #3;
    rst = 1'b1;
    for (int c = 0; c < 200; c++) begin
      rs1Addr     = RegAddr'($urandom_range(0, 4));
      rs2Addr     = RegAddr'($urandom_range(0, 4));
      issueValid  = $urandom_range(0, 1) == 1;
      issueRdAddr = RegAddr'($urandom_range(0, 4));
      wEnable     = $urandom_range(0, 1) == 1;
      rdAddr      = RegAddr'($urandom_range(0, 4));
      wData       = $urandom;
      flush       = $urandom_range(0, 29) == 0;
      step();
    end
    idle();
    atNeg();
    cmpEn = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
